mac_collector: RTL and testbench

- Downstream drain stage of the PE array; consumes the per-column bottom-row results `mac_o`/`mac_v_o`.
- Array results leave skewed: column j is valid one or more cycles after column j-1.
- The block buffers each column in its own FIFO, realigns rows, and serializes them as one element per cycle on a valid/ready stream.
- Output order is row-major: column 0 first. A sequencer sets the row count per job; the block pulses done when the last element has been handed off.

---
 rtl/mac_collector.sv | 188 ++++++++++++++++++
 tb/tb_mac_collector.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_collector.sv
// mac_collector
// Drain stage for the PE array. Each column's bottom-row result stream arrives
// skewed in time. It is captured into that column's own small FIFO. The column
// FIFOs are then read round-robin, so results leave as a row-major stream of
// one element per cycle on a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, num_rows_i  job start pulse and row count, both sampled in IDLE
//   mac_i, mac_v_i       per-column results and valids from the PE array
//   out_data_o           serialized element (FIFO head of the current column)
//   out_col_o            column index of out_data_o
//   out_last_o           high on the last column of a row
//   out_v_o, out_ready_i output valid / downstream ready
//   busy_o               high while a job is running
//   done_o               one-cycle pulse after the final element is handed off
//   overflow_o           sticky: a column result was dropped on a full FIFO
//
// Build option: define MAC_COLLECTOR_RELU_EN to clamp negative output elements
// to zero on the way out. FIFO contents and overflow logic are the same in
// both builds.
module mac_collector #(
    parameter int array_width = 8,
    parameter int mac_w       = 32,
    parameter int fifo_depth  = 4,
    parameter int row_cnt_w   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [row_cnt_w-1:0]                 num_rows_i,
    input  logic [array_width-1:0][mac_w-1:0]    mac_i,
    input  logic [array_width-1:0]               mac_v_i,
    output logic [mac_w-1:0]                     out_data_o,
    output logic [$clog2(array_width)-1:0]       out_col_o,
    output logic                                 out_last_o,
    output logic                                 out_v_o,
    input  logic                                 out_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overflow_o
);

    localparam int COL_W = $clog2(array_width);
    localparam int AW    = $clog2(fifo_depth);
    localparam int PW    = AW + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(array_width - 1);
    localparam logic [PW-1:0]    FULL_CNT = PW'(fifo_depth);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [row_cnt_w-1:0] target;
    logic [row_cnt_w-1:0] row_out;
    logic [COL_W-1:0]     col_ptr;
    logic [row_cnt_w-1:0] cap_cnt [array_width];
    logic [PW-1:0]        wr_ptr  [array_width];
    logic [PW-1:0]        rd_ptr  [array_width];
    logic [mac_w-1:0]     mem     [array_width][fifo_depth];

    logic [array_width-1:0] fifo_full;
    logic [array_width-1:0] fifo_empty;
    logic [array_width-1:0] want;
    logic [array_width-1:0] push;
    logic [array_width-1:0] drop;
    logic                   handshake;
    logic                   skip;
    logic                   advance;
    logic                   final_step;
    logic [mac_w-1:0]       head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    // Fullness uses this cycle's pointers, so a pop frees a slot for pushes
    // only from the next cycle on.
    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        want       = '0;
        push       = '0;
        drop       = '0;
        for (int j = 0; j < array_width; j++) begin
            fifo_full[j]  = (wr_ptr[j] - rd_ptr[j]) == FULL_CNT;
            fifo_empty[j] = (wr_ptr[j] == rd_ptr[j]);
            want[j]       = (state == RUN) && mac_v_i[j] && (cap_cnt[j] < target);
            push[j]       = want[j] && !fifo_full[j];
            drop[j]       = want[j] && fifo_full[j];
        end
    end

    assign out_v_o   = (state == RUN) && !fifo_empty[col_ptr];
    assign handshake = out_v_o && out_ready_i;

    // A column that lost entries to overflow can run dry before the job ends.
    // Once all of its results have arrived and its FIFO is empty, its slot is
    // stepped over so the remaining columns still drain and the job finishes.
    assign skip       = (state == RUN) && fifo_empty[col_ptr] && (cap_cnt[col_ptr] == target);
    assign advance    = handshake || skip;
    assign final_step = advance && (col_ptr == LAST_COL) && (row_out == target - 1'b1);

    assign head = mem[col_ptr][rd_ptr[col_ptr][AW-1:0]];

    // Output data is forced to zero while nothing is being presented, so every
    // output reads zero out of reset.
`ifdef MAC_COLLECTOR_RELU_EN
    assign out_data_o = (out_v_o && !head[mac_w-1]) ? head : '0;
`else
    assign out_data_o = out_v_o ? head : '0;
`endif
    assign out_col_o  = col_ptr;
    assign out_last_o = out_v_o && (col_ptr == LAST_COL);
    assign busy_o     = (state == RUN);
    assign done_o     = (state == DONE);

    // FIFO storage needs no reset; it is only read through a non-empty pointer pair.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < array_width; j++) begin
            if (push[j]) begin
                mem[j][wr_ptr[j][AW-1:0]] <= mac_i[j];
            end
        end
    end

    // Job sequencer: capture counters, FIFO pointers, readout position and
    // the sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            target     <= '0;
            row_out    <= '0;
            col_ptr    <= '0;
            overflow_o <= 1'b0;
            for (int j = 0; j < array_width; j++) begin
                cap_cnt[j] <= '0;
                wr_ptr[j]  <= '0;
                rd_ptr[j]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        overflow_o <= 1'b0;
                        if (num_rows_i != '0) begin
                            target  <= num_rows_i;
                            row_out <= '0;
                            col_ptr <= '0;
                            for (int j = 0; j < array_width; j++) begin
                                cap_cnt[j] <= '0;
                                wr_ptr[j]  <= '0;
                                rd_ptr[j]  <= '0;
                            end
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    for (int j = 0; j < array_width; j++) begin
                        if (push[j]) wr_ptr[j] <= wr_ptr[j] + 1'b1;
                        if (want[j]) cap_cnt[j] <= cap_cnt[j] + 1'b1;
                        if (drop[j]) overflow_o <= 1'b1;
                    end
                    if (handshake) begin
                        rd_ptr[col_ptr] <= rd_ptr[col_ptr] + 1'b1;
                    end
                    if (advance) begin
                        if (col_ptr == LAST_COL) begin
                            col_ptr <= '0;
                            row_out <= row_out + 1'b1;
                        end else begin
                            col_ptr <= col_ptr + 1'b1;
                        end
                    end
                    if (final_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_collector.sv
// tb_mac_collector
// Self-checking bench for mac_collector (default parameters: 8 columns,
// 32-bit results, depth-4 FIFOs). Expected output streams come from a
// row-major model of the injected values. The model applies ReLU when the
// bench is built with MAC_COLLECTOR_RELU_EN.
`timescale 1ns/1ps
module tb_mac_collector;

    localparam int NCOL = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  start_i;
    logic [7:0]            num_rows_i;
    logic [NCOL-1:0][31:0] mac_i;
    logic [NCOL-1:0]       mac_v_i;
    logic [31:0]           out_data_o;
    logic [2:0]            out_col_o;
    logic                  out_last_o;
    logic                  out_v_o;
    logic                  out_ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;

    mac_collector dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .mac_i       (mac_i),
        .mac_v_i     (mac_v_i),
        .out_data_o  (out_data_o),
        .out_col_o   (out_col_o),
        .out_last_o  (out_last_o),
        .out_v_o     (out_v_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    // Stimulus tables: sched[col][row] is the job-relative cycle at which
    // vals[row][col] is presented on that column.
    int          sched [NCOL][8];
    logic [31:0] vals  [8][NCOL];

    // Recorded handshakes and expected stream.
    logic [31:0] got_d[$];
    int          got_c[$];
    logic        got_l[$];
    logic [31:0] exp_d[$];
    int          exp_c[$];
    logic        exp_l[$];
    logic [31:0] stall_d[$];
    int          stall_c[$];

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    int v_cnt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (out_v_o && out_ready_i) begin
                got_d.push_back(out_data_o);
                got_c.push_back(int'(out_col_o));
                got_l.push_back(out_last_o);
                last_hs_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_v_o) v_cnt++;
        end
    end

    // Reference transform of one stored element on its way out.
    function automatic logic [31:0] model_out(input logic [31:0] v);
`ifdef MAC_COLLECTOR_RELU_EN
        if ($signed(v) < 0) return 32'd0;
        return v;
`else
        return v;
`endif
    endfunction

    // Expected stream for a lossless job: every row in order, column 0 first.
    task automatic build_exp(input int nrows);
        exp_d.delete(); exp_c.delete(); exp_l.delete();
        for (int r = 0; r < nrows; r++) begin
            for (int j = 0; j < NCOL; j++) begin
                exp_d.push_back(model_out(vals[r][j]));
                exp_c.push_back(j);
                exp_l.push_back(j == NCOL - 1);
            end
        end
    endtask

    // Skew pattern: column j sees row r on cycle r+j, value 10*r+j.
    task automatic fill_skew(input int nrows);
        for (int r = 0; r < nrows; r++)
            for (int j = 0; j < NCOL; j++) begin
                sched[j][r] = r + j;
                vals[r][j]  = 32'(10 * r + j);
            end
    endtask

    // Runs one job from the tables. Optional ready stall after stall_at
    // outputs, optional random ready, optional start pulse mid-job.
    task automatic run_job(input int nrows, input int stall_at, input int stall_len,
                           input bit rnd_ready, input int restart_at);
        int c = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        got_d.delete(); got_c.delete(); got_l.delete();
        stall_d.delete(); stall_c.delete();
        done_cnt = 0;
        start_i = 1'b1;
        num_rows_i = 8'(nrows);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (c < 600 && done_cnt == 0) begin
            mac_v_i = '0;
            for (int j = 0; j < NCOL; j++)
                for (int r = 0; r < nrows; r++)
                    if (sched[j][r] == c) begin
                        mac_v_i[j] = 1'b1;
                        mac_i[j]   = vals[r][j];
                    end
            start_i = (c == restart_at);
            num_rows_i = start_i ? 8'd1 : 8'(nrows);
            if (stall_len > 0 && !stalled && got_d.size() >= stall_at) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else begin
                out_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk_i);
            if (!out_ready_i && out_v_o) begin
                stall_d.push_back(out_data_o);
                stall_c.push_back(int'(out_col_o));
            end
            @(posedge clk_i); #1;
            c++;
        end
        mac_v_i = '0;
        start_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; num_rows_i = '0;
        mac_i = '0; mac_v_i = '0; out_ready_i = 1'b1;
        #12;
        checks++; if ({out_v_o, busy_o, done_o, overflow_o, out_last_o} !== 5'b0)
            $display("[TB] FAIL reset_flags: got v/busy/done/ovf/last=%b, expected 00000",
                     {out_v_o, busy_o, done_o, overflow_o, out_last_o}); else passes++;
        checks++; if (out_data_o !== 32'd0 || out_col_o !== 3'd0)
            $display("[TB] FAIL reset_data: got data=%h col=%0d, expected 0/0", out_data_o, out_col_o); else passes++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++; if ({out_v_o, busy_o, done_o} !== 3'b0)
            $display("[TB] FAIL idle_after_reset: got v/busy/done=%b, expected 000", {out_v_o, busy_o, done_o}); else passes++;
    endtask

    task automatic test_basic_skew();
        fill_skew(2);
        build_exp(2);
        run_job(2, 0, 0, 1'b0, -1);
        checks++; if (got_d.size() != exp_d.size())
            $display("[TB] FAIL basic_count: got %0d elements, expected %0d", got_d.size(), exp_d.size()); else passes++;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i] || got_l[i] !== exp_l[i])
                $display("[TB] FAIL basic_elem%0d: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                         i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]); else passes++;
        end
        checks++; if (done_cnt != 1 || done_cyc != last_hs_cyc + 1)
            $display("[TB] FAIL basic_done: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                     done_cnt, done_cyc, last_hs_cyc + 1); else passes++;
        checks++; if (overflow_o !== 1'b0 || busy_o !== 1'b0)
            $display("[TB] FAIL basic_end_flags: got ovf=%b busy=%b, expected 0/0", overflow_o, busy_o); else passes++;
    endtask

    task automatic test_backpressure();
        fill_skew(2);
        build_exp(2);
        run_job(2, 3, 6, 1'b0, -1);
        checks++; if (stall_d.size() != 6)
            $display("[TB] FAIL bp_stall_len: got %0d held cycles, expected 6", stall_d.size()); else passes++;
        for (int i = 0; i < stall_d.size(); i++) begin
            checks++; if (stall_d[i] !== model_out(vals[0][3]) || stall_c[i] != 3)
                $display("[TB] FAIL bp_hold%0d: got data=%h col=%0d, expected data=%h col=3",
                         i, stall_d[i], stall_c[i], model_out(vals[0][3])); else passes++;
        end
        checks++; if (got_d.size() != exp_d.size())
            $display("[TB] FAIL bp_count: got %0d elements, expected %0d", got_d.size(), exp_d.size()); else passes++;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i] || got_l[i] !== exp_l[i])
                $display("[TB] FAIL bp_elem%0d: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                         i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]); else passes++;
        end
        checks++; if (done_cnt != 1 || overflow_o !== 1'b0)
            $display("[TB] FAIL bp_end: got done=%0d ovf=%b, expected 1/0", done_cnt, overflow_o); else passes++;
    endtask

    // Random data, random per-column jitter and random downstream ready.
    task automatic test_random_jobs();
        int nrows;
        for (int job = 0; job < 3; job++) begin
            nrows = $urandom_range(1, 6);
            for (int r = 0; r < nrows; r++)
                for (int j = 0; j < NCOL; j++) begin
                    sched[j][r] = r * 16 + j + $urandom_range(0, 3);
                    vals[r][j]  = $urandom;
                end
            build_exp(nrows);
            run_job(nrows, 0, 0, 1'b1, -1);
            checks++; if (got_d.size() != exp_d.size())
                $display("[TB] FAIL rand%0d_count: got %0d elements, expected %0d", job, got_d.size(), exp_d.size()); else passes++;
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i] || got_l[i] !== exp_l[i])
                    $display("[TB] FAIL rand%0d_elem%0d: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                             job, i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]); else passes++;
            end
            checks++; if (done_cnt != 1 || overflow_o !== 1'b0)
                $display("[TB] FAIL rand%0d_end: got done=%0d ovf=%b, expected 1/0", job, done_cnt, overflow_o); else passes++;
        end
    endtask

    task automatic test_start_ignored();
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < NCOL; j++) begin
                sched[j][r] = r * 3 + j;
                vals[r][j]  = $urandom;
            end
        build_exp(3);
        run_job(3, 0, 0, 1'b0, 5);
        checks++; if (got_d.size() != exp_d.size())
            $display("[TB] FAIL restart_count: got %0d elements, expected %0d", got_d.size(), exp_d.size()); else passes++;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i])
                $display("[TB] FAIL restart_elem%0d: got data=%h col=%0d, expected data=%h col=%0d",
                         i, got_d[i], got_c[i], exp_d[i], exp_c[i]); else passes++;
        end
        checks++; if (done_cnt != 1)
            $display("[TB] FAIL restart_done: got %0d pulses, expected 1", done_cnt); else passes++;
    endtask

    task automatic test_overflow();
        int c = 0;
        got_d.delete(); got_c.delete(); got_l.delete();
        done_cnt = 0;
        out_ready_i = 1'b0;
        start_i = 1'b1; num_rows_i = 8'd6;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mac_v_i = 8'b0000_0001;
            mac_i[0] = 32'd100 + 32'(k);
            @(posedge clk_i); #1;
            if (k == 3) begin
                checks++; if (overflow_o !== 1'b0)
                    $display("[TB] FAIL ovf_at_4: got %b, expected 0", overflow_o); else passes++;
            end
            if (k == 4) begin
                checks++; if (overflow_o !== 1'b1)
                    $display("[TB] FAIL ovf_at_5: got %b, expected 1", overflow_o); else passes++;
            end
        end
        mac_v_i = '0;
        checks++; if (out_v_o !== 1'b1 || out_data_o !== model_out(32'd100) || out_col_o !== 3'd0)
            $display("[TB] FAIL ovf_head: got v=%b data=%h col=%0d, expected 1/%h/0",
                     out_v_o, out_data_o, out_col_o, model_out(32'd100)); else passes++;
        out_ready_i = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < NCOL; j++) begin
                vals[r][j] = 32'd200 + 32'(16 * r + j);
                mac_i[j] = vals[r][j];
            end
            mac_v_i = '1;
            @(posedge clk_i); #1;
            mac_v_i = '0;
            repeat (9) @(posedge clk_i);
            #1;
        end
        while (done_cnt == 0 && c < 100) begin
            @(posedge clk_i); #1;
            c++;
        end
        // Column 0 keeps only its first four results; its later rows are lost.
        exp_d.delete(); exp_c.delete(); exp_l.delete();
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < NCOL; j++) begin
                if (j == 0 && r >= 4) continue;
                exp_d.push_back(model_out(j == 0 ? 32'd100 + 32'(r) : vals[r][j]));
                exp_c.push_back(j);
                exp_l.push_back(j == NCOL - 1);
            end
        checks++; if (got_d.size() != exp_d.size())
            $display("[TB] FAIL ovf_count: got %0d elements, expected %0d", got_d.size(), exp_d.size()); else passes++;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i] || got_l[i] !== exp_l[i])
                $display("[TB] FAIL ovf_elem%0d: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                         i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]); else passes++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (done_cnt != 1 || overflow_o !== 1'b1)
            $display("[TB] FAIL ovf_end: got done=%0d ovf=%b, expected 1/1", done_cnt, overflow_o); else passes++;
    endtask

    task automatic test_zero_rows();
        int v_before;
        done_cnt = 0;
        v_before = v_cnt;
        start_i = 1'b1; num_rows_i = 8'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || out_v_o !== 1'b0)
            $display("[TB] FAIL zero_done: got done=%b busy=%b v=%b, expected 1/0/0", done_o, busy_o, out_v_o); else passes++;
        checks++; if (overflow_o !== 1'b0)
            $display("[TB] FAIL zero_ovf_clear: got %b, expected 0", overflow_o); else passes++;
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0 || done_cnt != 1 || v_cnt != v_before)
            $display("[TB] FAIL zero_after: got done=%b pulses=%0d v_cycles=%0d, expected 0/1/0",
                     done_o, done_cnt, v_cnt - v_before); else passes++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid_job();
        int c = 0;
        fill_skew(2);
        got_d.delete(); got_c.delete(); got_l.delete();
        done_cnt = 0;
        out_ready_i = 1'b1;
        start_i = 1'b1; num_rows_i = 8'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (got_d.size() < 3 && c < 50) begin
            mac_v_i = '0;
            for (int j = 0; j < NCOL; j++)
                for (int r = 0; r < 2; r++)
                    if (sched[j][r] == c) begin
                        mac_v_i[j] = 1'b1;
                        mac_i[j] = vals[r][j];
                    end
            @(posedge clk_i); #1;
            c++;
        end
        mac_v_i = '0;
        rst_ni = 1'b0;
        #1;
        checks++; if ({out_v_o, busy_o, done_o, overflow_o, out_last_o} !== 5'b0 ||
                      out_data_o !== 32'd0 || out_col_o !== 3'd0)
            $display("[TB] FAIL midreset_outputs: got v/busy/done/ovf/last=%b data=%h col=%0d, expected all 0",
                     {out_v_o, busy_o, done_o, overflow_o, out_last_o}, out_data_o, out_col_o); else passes++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (done_cnt != 0)
            $display("[TB] FAIL midreset_no_done: got %0d pulses, expected 0", done_cnt); else passes++;
        fill_skew(1);
        build_exp(1);
        run_job(1, 0, 0, 1'b0, -1);
        checks++; if (got_d.size() != exp_d.size())
            $display("[TB] FAIL fresh_count: got %0d elements, expected %0d", got_d.size(), exp_d.size()); else passes++;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i] || got_l[i] !== exp_l[i])
                $display("[TB] FAIL fresh_elem%0d: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                         i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]); else passes++;
        end
        checks++; if (done_cnt != 1)
            $display("[TB] FAIL fresh_done: got %0d pulses, expected 1", done_cnt); else passes++;
    endtask

    task automatic test_relu();
        logic [31:0] want0;
`ifdef MAC_COLLECTOR_RELU_EN
        want0 = 32'h0000_0000;
`else
        want0 = 32'hFFFF_FFFB;
`endif
        fill_skew(1);
        vals[0][0] = 32'hFFFF_FFFB;
        vals[0][1] = 32'd7;
        run_job(1, 0, 0, 1'b0, -1);
        checks++; if (got_d.size() < 2 || got_d[0] !== want0)
            $display("[TB] FAIL relu_neg: got %h, expected %h", (got_d.size() > 0) ? got_d[0] : 32'hx, want0); else passes++;
        checks++; if (got_d.size() < 2 || got_d[1] !== 32'd7)
            $display("[TB] FAIL relu_pos: got %h, expected 00000007", (got_d.size() > 1) ? got_d[1] : 32'hx); else passes++;
    endtask

    initial begin
        $display("[TB] mac_collector bench start");
        test_reset();
        test_basic_skew();
        test_backpressure();
        test_random_jobs();
        test_start_ignored();
        test_overflow();
        test_zero_rows();
        test_reset_mid_job();
        test_relu();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
